// File: rtl/pet2001_prg_loader_if.sv
// pet2001_prg_loader_if
//   Bundles the .PRG byte-stream handshake, the DMA write port into PET RAM,
//   and the loader status outputs.
//   master : loader side (drives in_ready, dma_*, status)
//   slave  : environment side (drives start, patch_en, in_data/in_valid/in_last)
//   Signals:
//     start, patch_en                 control from host
//     in_data[7:0], in_valid, in_last byte stream into the loader
//     in_ready                        loader accepts a byte this cycle
//     dma_addr[15:0], dma_din[7:0], dma_we   RAM write port
//     busy, done, err_short, err_ovf  status
//     load_addr[15:0], end_addr[15:0] header load address / end of payload
interface pet2001_prg_loader_if;
    logic        start;
    logic        patch_en;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        busy;
    logic        done;
    logic        err_short;
    logic        err_ovf;
    logic [15:0] load_addr;
    logic [15:0] end_addr;

    modport master (
        input  start, patch_en, in_data, in_valid, in_last,
        output in_ready, dma_addr, dma_din, dma_we, busy, done,
               err_short, err_ovf, load_addr, end_addr
    );

    modport slave (
        output start, patch_en, in_data, in_valid, in_last,
        input  in_ready, dma_addr, dma_din, dma_we, busy, done,
               err_short, err_ovf, load_addr, end_addr
    );
endinterface

// File: rtl/pet2001_prg_loader.sv
// pet2001_prg_loader
//   Converts a .PRG byte stream (2-byte little-endian load address followed by
//   payload) into one-byte-per-cycle DMA writes into the 32KB PET RAM, and can
//   afterwards patch the BASIC 4 VARTAB/ARYTAB/STREND pointers with the end
//   address so RUN works immediately.
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      pet2001_prg_loader_if.master (stream in, DMA out, status)
module pet2001_prg_loader #(
    parameter logic [15:0] RAM_TOP  = 16'h8000,
    parameter logic [7:0]  PTR_BASE = 8'h2A,
    parameter int unsigned NUM_PTRS = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    pet2001_prg_loader_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        PATCH,
        FIN
    } state_t;

    localparam logic [7:0] PATCH_LAST = 8'(2 * NUM_PTRS - 1);

    state_t      state;
    state_t      state_nxt;
    logic        ready;
    logic        xfer;
    logic        patch_q;
    logic [15:0] cur_addr;
    logic [7:0]  ptr_idx;
    logic [15:0] dma_addr_q;
    logic [7:0]  dma_din_q;
    logic        dma_we_q;
    logic        err_short_q;
    logic        err_ovf_q;
    logic [15:0] load_addr_q;
    logic [15:0] end_addr_q;

    assign bus.in_ready  = ready;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.dma_addr  = dma_addr_q;
    assign bus.dma_din   = dma_din_q;
    assign bus.dma_we    = dma_we_q;
    assign bus.err_short = err_short_q;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.load_addr = load_addr_q;
    assign bus.end_addr  = end_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            HDR_LO, HDR_HI, DATA: ready = 1'b1;
            default:              ready = 1'b0;
        endcase
        xfer = bus.in_valid & ready;

        // start overrides everything, including a same-cycle transfer
        if (bus.start) begin
            state_nxt = HDR_LO;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                HDR_LO:  if (xfer) state_nxt = bus.in_last ? FIN : HDR_HI;
                HDR_HI:  if (xfer) state_nxt = bus.in_last ? FIN : DATA;
                DATA:    if (xfer && bus.in_last) state_nxt = patch_q ? PATCH : FIN;
                PATCH:   if (ptr_idx == PATCH_LAST) state_nxt = FIN;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            patch_q     <= 1'b0;
            cur_addr    <= '0;
            ptr_idx     <= '0;
            dma_addr_q  <= '0;
            dma_din_q   <= '0;
            dma_we_q    <= 1'b0;
            err_short_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            load_addr_q <= '0;
            end_addr_q  <= '0;
        end else begin
            dma_we_q <= 1'b0;
            if (bus.start) begin
                patch_q     <= bus.patch_en;
                err_short_q <= 1'b0;
                err_ovf_q   <= 1'b0;
                ptr_idx     <= '0;
            end else begin
                case (state)
                    HDR_LO: if (xfer) begin
                        load_addr_q[7:0] <= bus.in_data;
                        if (bus.in_last) err_short_q <= 1'b1;
                    end
                    HDR_HI: if (xfer) begin
                        load_addr_q[15:8] <= bus.in_data;
                        cur_addr          <= {bus.in_data, load_addr_q[7:0]};
                        if (bus.in_last) err_short_q <= 1'b1;
                    end
                    DATA: if (xfer) begin
                        // bytes at/above RAM_TOP are dropped; dma_addr/din keep
                        // their last written value so bit 15 never shows
                        if (cur_addr < RAM_TOP) begin
                            dma_addr_q <= cur_addr;
                            dma_din_q  <= bus.in_data;
                            dma_we_q   <= 1'b1;
                        end else begin
                            err_ovf_q  <= 1'b1;
                        end
                        cur_addr <= cur_addr + 16'd1;
                        ptr_idx  <= '0;
                        if (bus.in_last) end_addr_q <= cur_addr + 16'd1;
                    end
                    PATCH: begin
                        dma_addr_q <= {8'h00, 8'(PTR_BASE + ptr_idx)};
                        dma_din_q  <= ptr_idx[0] ? end_addr_q[15:8] : end_addr_q[7:0];
                        dma_we_q   <= 1'b1;
                        ptr_idx    <= ptr_idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pet2001_prg_loader.sv
// tb_pet2001_prg_loader
//   Drives .PRG streams into pet2001_prg_loader and checks DMA writes, handshake
//   and status against a file-level model of the loader kept in this bench.
module tb_pet2001_prg_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pet2001_prg_loader_if bus();

    pet2001_prg_loader #(
        .RAM_TOP (16'h8000),
        .PTR_BASE(8'h2A),
        .NUM_PTRS(3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         expq[$];
    logic [23:0] got[$];
    logic [7:0]  mem_dut [65536];

    int          cyc = 0;
    int          m_idx = 0;
    int          m_done_cyc = -1;
    logic [15:0] m_load = '0;
    logic [15:0] m_end = '0;
    logic [15:0] m_a = '0;
    bit          m_patch = 0;
    bit          m_stream = 0;
    bit          m_active = 0;
    bit          m_short = 0;
    bit          m_ovf = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            expq.delete();
            m_stream   = 0;
            m_active   = 0;
            m_done_cyc = -1;
        end else begin
            chk("in_ready", bus.in_ready, m_stream);
            chk("busy", bus.busy, m_active);
            chk("dma_addr_bit15", bus.dma_addr[15], 1'b0);
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                chk("dma_we", bus.dma_we, 1'b1);
                chk("dma_addr", bus.dma_addr, expq[0].a);
                chk("dma_din", bus.dma_din, expq[0].d);
                void'(expq.pop_front());
            end else begin
                chk("dma_we_quiet", bus.dma_we, 1'b0);
            end
            if (bus.dma_we) begin
                got.push_back({bus.dma_addr, bus.dma_din});
                mem_dut[bus.dma_addr] = bus.dma_din;
            end
            chk("done", bus.done, m_done_cyc == cyc);
            if (m_done_cyc == cyc) begin
                chk("err_short", bus.err_short, m_short);
                chk("err_ovf", bus.err_ovf, m_ovf);
                if (m_idx >= 2) chk("load_addr", bus.load_addr, m_load);
                if (m_idx >= 3) chk("end_addr", bus.end_addr, m_end);
                m_active   = 0;
                m_done_cyc = -1;
            end
            if (bus.start) begin
                expq.delete();
                m_stream   = 1;
                m_active   = 1;
                m_idx      = 0;
                m_short    = 0;
                m_ovf      = 0;
                m_patch    = bus.patch_en;
                m_done_cyc = -1;
            end else if (bus.in_valid && m_stream) begin
                if (m_idx == 0) m_load[7:0] = bus.in_data;
                else if (m_idx == 1) m_load[15:8] = bus.in_data;
                else begin
                    m_a = m_load + 16'(m_idx - 2);
                    if (m_a < 16'h8000) expq.push_back('{cyc + 1, m_a, bus.in_data});
                    else m_ovf = 1;
                end
                if (bus.in_last) begin
                    m_stream = 0;
                    if (m_idx < 2) begin
                        m_short    = 1;
                        m_done_cyc = cyc + 1;
                    end else begin
                        m_end = m_a + 16'd1;
                        if (m_patch) begin
                            for (int k = 0; k < 6; k++)
                                expq.push_back('{cyc + 2 + k, 16'h002A + 16'(k),
                                                 (k % 2 == 1) ? m_end[15:8] : m_end[7:0]});
                            m_done_cyc = cyc + 7;
                        end else begin
                            m_done_cyc = cyc + 1;
                        end
                    end
                end
                m_idx++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_file(input logic [7:0] f[$], input bit pe, input int unsigned vpct,
                             input int abort_at, input bit valid_at_start);
        int i = 0;
        int guard = 0;
        int n = 0;
        bit hs;
        @(posedge clk); #1;
        got.delete();
        bus.start    = 1'b1;
        bus.patch_en = pe;
        bus.in_valid = valid_at_start;
        bus.in_data  = 8'h55;
        bus.in_last  = 1'b0;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        while (i < f.size() && guard < 20000) begin
            bus.in_valid = ($urandom_range(99) < vpct);
            bus.in_data  = f[i];
            bus.in_last  = (i == f.size() - 1);
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) i++;
            if (abort_at >= 0 && i == abort_at) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (i < f.size()) chk("stream_timeout", i, f.size());
        while (n < 50 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", bus.done, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [7:0]  f[$];
    logic [23:0] e1[9] = '{24'h0401A9, 24'h040200, 24'h040360, 24'h002A04, 24'h002B04,
                           24'h002C04, 24'h002D04, 24'h002E04, 24'h002F04};
    logic [15:0] ld;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.patch_en = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dma_we", bus.dma_we, 1'b0);
        chk("rst_dma_addr", bus.dma_addr, 16'h0000);
        chk("rst_dma_din", bus.dma_din, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_err", {bus.err_short, bus.err_ovf}, 2'b00);
        chk("rst_load_addr", bus.load_addr, 16'h0000);
        chk("rst_end_addr", bus.end_addr, 16'h0000);
        reset_n = 1'b1;

        // small program with pointer patch
        f = '{8'h01, 8'h04, 8'hA9, 8'h00, 8'h60};
        send_file(f, 1'b1, 100, -1, 1'b0);
        chk("t1_nwrites", got.size(), 9);
        for (int i = 0; i < 9; i++) if (i < got.size()) chk("t1_write", got[i], e1[i]);
        chk("t1_end_addr", bus.end_addr, 16'h0404);

        // crossing RAM_TOP
        f = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33};
        send_file(f, 1'b0, 100, -1, 1'b0);
        chk("t2_nwrites", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2_write0", got[0], 24'h7FFE11);
            chk("t2_write1", got[1], 24'h7FFF22);
        end
        chk("t2_err_ovf", bus.err_ovf, 1'b1);
        chk("t2_end_addr", bus.end_addr, 16'h8001);

        // truncated header
        f = '{8'h34};
        send_file(f, 1'b1, 100, -1, 1'b0);
        chk("t3_nwrites", got.size(), 0);
        chk("t3_err_short", bus.err_short, 1'b1);
        chk("t3_busy_after", bus.busy, 1'b0);

        // 200-byte payload with random valid gaps
        f = '{8'h00, 8'h10};
        for (int i = 0; i < 200; i++) f.push_back(8'($urandom));
        send_file(f, 1'b0, 50, -1, 1'b0);
        chk("t4_nwrites", got.size(), 200);
        for (int i = 0; i < 200; i++) chk("t4_mem", mem_dut[16'h1000 + 16'(i)], f[i + 2]);

        // abort after 10 payload bytes, restart with a byte offered during start
        f = '{8'hF8, 8'h7F};
        for (int i = 0; i < 20; i++) f.push_back(8'($urandom));
        send_file(f, 1'b1, 70, 12, 1'b0);
        chk("t5_ovf_before", bus.err_ovf, 1'b1);
        f = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
        send_file(f, 1'b0, 80, -1, 1'b1);
        chk("t5_ovf_cleared", bus.err_ovf, 1'b0);
        chk("t5_mem", {mem_dut[16'h0200], mem_dut[16'h0201], mem_dut[16'h0202]}, 24'hDEADBE);

        // random files, including wrap past FFFF and RAM_TOP crossings
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(2))
                0:       ld = 16'($urandom_range(16'h7F00));
                1:       ld = 16'h7FF0 + 16'($urandom_range(15));
                default: ld = 16'hFFF0 + 16'($urandom_range(15));
            endcase
            f = '{ld[7:0], ld[15:8]};
            for (int i = 0; i < int'($urandom_range(40, 1)); i++) f.push_back(8'($urandom));
            send_file(f, 1'($urandom_range(1)), $urandom_range(100, 30), -1, 1'b0);
        end

        // asynchronous reset during pointer patch
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.patch_en = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        f = '{8'h00, 8'h30, 8'h01, 8'h02};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            bus.in_last  = (i == 3);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        begin
            int n = 0;
            while (n < 20 && !(bus.dma_we && bus.dma_addr == 16'h002C)) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6_in_patch", {bus.dma_we, bus.dma_addr}, {1'b1, 16'h002C});
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_we_async", bus.dma_we, 1'b0);
        chk("t6_busy_async", bus.busy, 1'b0);
        chk("t6_ready_async", bus.in_ready, 1'b0);
        chk("t6_done_async", bus.done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        f = '{8'h00, 8'h05, 8'h77};
        send_file(f, 1'b0, 100, -1, 1'b0);
        chk("t6_recover", mem_dut[16'h0500], 8'h77);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
